// File: rtl/seg7_ascii_capture.sv
// Seven-segment bus capture: debounces each displayed pattern, re-encodes
// it to an ASCII digit and streams it out through a small FWFT FIFO.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   seg_in      active-low segment bus, bit0 = a ... bit6 = g
//   ascii_out   ASCII byte at the FIFO head
//   ascii_valid FIFO non-empty
//   ascii_ready consumer accepts ascii_out with ascii_valid
//   fifo_count  current FIFO occupancy
//   overflow    sticky, a character was dropped on a full FIFO
//   err_count   saturating count of unrecognised patterns
module seg7_ascii_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [7:0]       ascii_out,
  output logic             ascii_valid,
  input  logic             ascii_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic [7:0]       err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [6:0] BLANK = 7'h7F;

  // {recognised, ascii}
  function automatic logic [8:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = {1'b1, 8'h30};
      7'h79:   decode = {1'b1, 8'h31};
      7'h24:   decode = {1'b1, 8'h32};
      7'h30:   decode = {1'b1, 8'h33};
      7'h19:   decode = {1'b1, 8'h34};
      7'h12:   decode = {1'b1, 8'h35};
      7'h02:   decode = {1'b1, 8'h36};
      7'h78:   decode = {1'b1, 8'h37};
      7'h00:   decode = {1'b1, 8'h38};
      7'h10:   decode = {1'b1, 8'h39};
      default: decode = {1'b0, 8'h3F};
    endcase
  endfunction

  logic [6:0]       seg_s_q, seg_s_d;
  logic [7:0]       stab_q, stab_d;
  logic [6:0]       last_q, last_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       mem [FIFO_DEPTH];

  logic       same, acc, push, pop, full, wr_en;
  logic [8:0] dec;

  always_comb begin
    same  = (seg_in == seg_s_q);
    acc   = same && (stab_q == STAB_LAST) &&
            (seg_s_q != last_q);
    dec   = decode(seg_s_q);
    push  = acc && (seg_s_q != BLANK);
    pop   = (cnt_q != '0) && ascii_ready;
    full  = (cnt_q == FULL);
    // A pop on the same edge frees the slot, so a full FIFO still
    // takes the new character.
    wr_en = push && (!full || pop);

    seg_s_d = seg_in;
    if (!same)
      stab_d = '0;
    else if (stab_q < STAB_MAX)
      stab_d = stab_q + 8'd1;
    else
      stab_d = stab_q;
    last_d = acc ? seg_s_q : last_q;

    wr_d   = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    hold_d = pop ? mem[rd_q] : hold_q;
    cnt_d  = cnt_q;
    if (wr_en && !pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!wr_en && pop)
      cnt_d = cnt_q - CNT_W'(1);

    ovf_d = ovf_q | (push && !wr_en);
    err_d = err_q;
    if (push && !dec[8] && err_q != 8'hFF)
      err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s_q <= BLANK;
      stab_q  <= '0;
      last_q  <= BLANK;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      seg_s_q <= seg_s_d;
      stab_q  <= stab_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_q] <= dec[7:0];
  end

  // When empty, keep showing the last byte handed out.
  assign ascii_valid = (cnt_q != '0);
  assign ascii_out   = ascii_valid ? mem[rd_q] : hold_q;
  assign fifo_count  = cnt_q;
  assign overflow    = ovf_q;
  assign err_count   = err_q;

endmodule
